reg_bank_wr_demux: RTL and testbench

- 8 x 16-bit register bank for the multicycle RISC datapath, driven by a 1-to-8 write demultiplexer on a 3-bit destination address. It is the distribution end of the datapath's 3-bit-select, 16-bit operand selection.
- Provides two combinational read ports with write-through bypass, a dedicated R7 (PC) update port, and a per-register busy scoreboard. The control FSM uses the scoreboard to stall on pending multicycle results.

---
 rtl/reg_bank_wr_demux.sv | 84 ++++++++
 tb/tb_reg_bank_wr_demux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wr_demux.sv
// Register bank for the multicycle datapath: a one-hot write demux feeds the storage,
// with a dedicated PC write port, two bypassed combinational read ports and a busy scoreboard.
module reg_bank_wr_demux #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_wr,
  input  logic [DATA_W-1:0] pc_data,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DATA_W-1:0] r7_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  wr_dec;
  logic [DEPTH-1:0]  set_dec;
  logic [DEPTH-1:0]  busy_nxt;

  always_comb begin
    wr_dec  = '0;
    set_dec = '0;
    if (wr_en)    wr_dec[wr_addr]    = 1'b1;
    if (busy_set) set_dec[busy_addr] = 1'b1;
  end

  // Set is applied after clear so a new producer issued while the old one retires stays pending.
  assign busy_nxt = (busy & ~wr_dec) | set_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec[i])
          regs[i] <= wr_data;
        else if (pc_wr && (i == PC_REG))
          regs[i] <= pc_data;
      end
      busy <= busy_nxt;
    end
  end

  logic wr_hit_a, wr_hit_b, pc_hit_a, pc_hit_b;

  assign wr_hit_a = wr_en && (wr_addr == rd_addr_a);
  assign wr_hit_b = wr_en && (wr_addr == rd_addr_b);
  assign pc_hit_a = pc_wr && (rd_addr_a == PC_ADDR);
  assign pc_hit_b = pc_wr && (rd_addr_b == PC_ADDR);

  // Bypass order mirrors write priority: write-back beats the PC port, which beats storage.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_hit_a)      rd_data_a = wr_data;
    else if (pc_hit_a) rd_data_a = pc_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (wr_hit_b)      rd_data_b = wr_data;
    else if (pc_hit_b) rd_data_b = pc_data;
  end

  assign busy_a = busy[rd_addr_a] && !wr_hit_a;
  assign busy_b = busy[rd_addr_b] && !wr_hit_b;
  assign r7_out = regs[PC_REG];

endmodule

// File: tb/tb_reg_bank_wr_demux.sv
// Directed plus randomized bench for reg_bank_wr_demux, checked against an array-based
// model of the bank, its scoreboard and the read bypass rules.
module tb_reg_bank_wr_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_wr;
  logic [15:0] pc_data;
  logic        busy_set;
  logic [2:0]  busy_addr;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic [15:0] r7_out;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] m_reg  [8];
  logic        m_busy [8];

  always #5 clk = ~clk;

  reg_bank_wr_demux dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_wr     (pc_wr),
    .pc_data   (pc_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .r7_out    (r7_out)
  );

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (wr_en && wr_addr == a)  return wr_data;
    if (pc_wr && a == 3'd7)     return pc_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
    chk("busy_a", {15'd0, busy_a}, {15'd0, exp_busy(rd_addr_a)});
    chk("busy_b", {15'd0, busy_b}, {15'd0, exp_busy(rd_addr_b)});
    chk("r7_out", r7_out, m_reg[7]);
  endtask

  // Model of one clock edge; pc update applied first so a same-cycle write-back overrides it.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 16'h0000;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (pc_wr)    m_reg[7] = pc_data;
      if (wr_en)    begin m_reg[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
      if (busy_set) m_busy[busy_addr] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_wr = 1'b0; pc_data = '0; busy_set = 1'b0; busy_addr = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1; rd_addr_a = '0; rd_addr_b = '0;
    clk_edge();
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      settle();
      chk("reset_rd_a", rd_data_a, 16'h0000);
      chk("reset_busy_a", {15'd0, busy_a}, 16'h0000);
      clk_edge();
    end
    chk("reset_r7", r7_out, 16'h0000);

    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
    settle(); clk_edge();
    idle();
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(a);
      settle();
      chk("demux_iso", rd_data_a, (a == 3) ? 16'hA5A5 : 16'h0000);
      clk_edge();
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
    settle(); clk_edge();
    idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    settle();
    chk("demux_r3_kept", rd_data_a, 16'hA5A5);
    chk("demux_r0", rd_data_b, 16'h1234);
    clk_edge();

    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr_a = 3'd5;
    settle();
    chk("bypass_same", rd_data_a, 16'hBEEF);
    clk_edge();
    idle();
    settle();
    chk("bypass_next", rd_data_a, 16'hBEEF);
    clk_edge();

    pc_wr = 1'b1; pc_data = 16'h0010; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0200;
    rd_addr_a = 3'd7;
    settle();
    chk("pc_prio_comb", rd_data_a, 16'h0200);
    clk_edge();
    idle();
    settle();
    chk("pc_prio_r7", r7_out, 16'h0200);
    clk_edge();
    pc_wr = 1'b1; pc_data = 16'h0011;
    settle(); clk_edge();
    idle();
    settle();
    chk("pc_alone_r7", r7_out, 16'h0011);
    clk_edge();

    busy_set = 1'b1; busy_addr = 3'd2;
    settle(); clk_edge();
    idle(); rd_addr_a = 3'd2;
    settle();
    chk("sb_set", {15'd0, busy_a}, 16'h0001);
    clk_edge();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    settle();
    chk("sb_retire_comb", {15'd0, busy_a}, 16'h0000);
    clk_edge();
    idle();
    settle();
    chk("sb_retired", {15'd0, busy_a}, 16'h0000);
    clk_edge();
    busy_set = 1'b1; busy_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
    settle(); clk_edge();
    idle(); rd_addr_a = 3'd4;
    settle();
    chk("sb_both_data", rd_data_a, 16'h4444);
    chk("sb_both_busy", {15'd0, busy_a}, 16'h0001);
    clk_edge();

    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h7777;
    settle(); clk_edge();
    idle(); busy_set = 1'b1; busy_addr = 3'd6;
    settle(); clk_edge();
    idle();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1111;
    busy_set = 1'b1; busy_addr = 3'd1;
    settle(); clk_edge();
    idle(); rd_addr_a = 3'd6; rd_addr_b = 3'd1;
    settle();
    chk("rst_mid_r6", rd_data_a, 16'h0000);
    chk("rst_mid_busy6", {15'd0, busy_a}, 16'h0000);
    chk("rst_mid_busy1", {15'd0, busy_b}, 16'h0000);
    clk_edge();

    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      pc_wr     = ($urandom_range(0, 3) == 0);
      pc_data   = 16'($urandom);
      busy_set  = $urandom_range(0, 1);
      busy_addr = 3'($urandom_range(0, 7));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
      settle();
      clk_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
